// File: rtl/muldiv_unit.sv
// ============================================================================
// Module  : muldiv_unit
// Brief   : Iterative radix-2 HI/LO multiply/divide unit (MULT[U]/DIV[U]).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_busy;
  logic                 w_accept;

  logic [c_cnt_w-1:0]   r_step;
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]     r_m;
  logic                 r_op_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_a_neg;
  logic                 w_b_neg;
  logic                 w_b_zero;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_add;
  logic [2*WIDTH-1:0]   w_mul_nxt;
  logic [WIDTH:0]       w_shift;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_sub;
  logic [WIDTH-1:0]     w_rem_nxt;
  logic [2*WIDTH-1:0]   w_div_nxt;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CALC;
          w_accept    = 1'b1;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (r_step == c_last) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_busy      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- operand prep
  // A zero divisor forces a positive quotient so the all-ones pattern and
  // the sign-restored dividend fall out of the normal datapath.
  always_comb begin
    w_a_neg  = op[0] & a[WIDTH-1];
    w_b_neg  = op[0] & b[WIDTH-1];
    w_b_zero = (b == '0);
    w_abs_a  = w_a_neg ? -a : a;
    w_abs_b  = w_b_neg ? -b : b;
  end

  // ---------------------------------------------------------- step logic
  always_comb begin
    w_add     = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
    w_mul_nxt = {w_add, r_p[WIDTH-1:1]};

    w_shift   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    w_ge      = (w_shift >= {1'b0, r_m});
    w_sub     = w_shift[WIDTH-1:0] - r_m;
    w_rem_nxt = w_ge ? w_sub : w_shift[WIDTH-1:0];
    w_div_nxt = {w_rem_nxt, r_p[WIDTH-2:0], w_ge};

    w_prod_fix = r_neg_q ? -r_p : r_p;
    w_quot     = r_p[WIDTH-1:0];
    w_rem      = r_p[2*WIDTH-1:WIDTH];
    w_quot_fix = r_neg_q ? -w_quot : w_quot;
    w_rem_fix  = r_neg_r ? -w_rem : w_rem;
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step   <= '0;
      r_p      <= '0;
      r_m      <= '0;
      r_op_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);

      if (w_accept) begin
        r_step   <= '0;
        r_p      <= {{WIDTH{1'b0}}, w_abs_a};
        r_m      <= w_abs_b;
        r_op_div <= op[1];
        r_neg_q  <= (w_a_neg ^ w_b_neg) & ~(op[1] & w_b_zero);
        r_neg_r  <= w_a_neg;
      end else if (r_state == S_CALC) begin
        r_p    <= r_op_div ? w_div_nxt : w_mul_nxt;
        r_step <= (r_step == c_last) ? '0 : r_step + 1'b1;
      end

      // Result registers only change on the FIX edge or a direct write while idle.
      if (r_state == S_FIX) begin
        if (r_op_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quot_fix;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end else if (!w_busy) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >=4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only when busy=0.
REQ-005 SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a  input  WIDTH  multiplicand / dividend (rs).
REQ-007 SHALL have port b  input  WIDTH  multiplier / divisor (rt).
REQ-008 SHALL have port hi_we  input  1  direct HI write (MTHI).
REQ-009 SHALL have port lo_we  input  1  direct LO write (MTLO).
REQ-010 SHALL have port wdata  input  WIDTH  data for hi_we/lo_we.
REQ-011 SHALL have port busy  output  1  operation in progress; core stalls MFHI/MFLO/new op.
REQ-012 SHALL have port done  output  1  one-cycle pulse: hi/lo now hold the new result.
REQ-013 SHALL have port hi  output  WIDTH  HI register (product upper half / remainder).
REQ-014 SHALL have port lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FIX; busy=1 exactly in CALC and FIX.
REQ-016 IDLE->CALC SHALL occur on the edge where start=1 and busy=0; a, b, op latched at that edge; later input changes ignored.
REQ-017 SHALL perform signed ops by converting operands to magnitudes at latch time and recording the result signs.
REQ-018 CALC SHALL last exactly WIDTH cycles: one radix-2 step per cycle (shift-add multiply; restoring divide), step counter counts 0..WIDTH-1 then CALC->FIX.
REQ-019 FIX SHALL last one cycle: apply sign correction, write hi/lo on its closing edge, go to IDLE.
REQ-020 done SHALL be 1 for exactly the one cycle following the FIX edge, coincident with busy=0; latency start-edge to done = WIDTH+1 cycles.
REQ-021 MULTU/MULT: {hi,lo} SHALL equal the full 2*WIDTH-bit unsigned/two's-complement product.
REQ-022 DIVU/DIV: lo SHALL equal quotient truncated toward zero; hi SHALL equal remainder with sign of dividend.
REQ-023 Divide by zero (b=0, DIVU or DIV): lo SHALL be all ones, hi SHALL be a, normal latency, no flag.
REQ-024 DIV overflow (a=most-negative, b=-1): lo SHALL be most-negative, hi SHALL be 0.
REQ-025 start while busy=1 SHALL be ignored (no queueing); start in the done cycle (busy=0) SHALL be accepted.
REQ-026 hi_we/lo_we SHALL update hi/lo with wdata only when busy=0; ignored while busy=1.
REQ-027 hi_we/lo_we and accepted start in the same cycle: write SHALL take effect; completion of the started op later overwrites both.
REQ-028 hi/lo SHALL hold value at all times other than REQ-019/REQ-026 writes; intermediate CALC state SHALL NOT appear on hi/lo.

Reset
REQ-029 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, hi=0, lo=0, step counter=0.
REQ-030 reset asserted mid-CALC/FIX SHALL abort the operation with no hi/lo update; after release, first start behaves as from power-up.
REQ-031 start sampled on the first clk edge after reset release SHALL be accepted normally.

Verification
REQ-032 WIDTH=32, MULT a=0xFFFFFFFD(-3), b=7 -> done 33 cycles after start edge, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 WIDTH=32, MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
REQ-034 WIDTH=32, DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
REQ-035 WIDTH=32, DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; then hi_we wdata=0x1234 when idle -> hi=0x1234, lo unchanged.
REQ-036 Start MULTU, pulse start and hi_we mid-CALC, then assert reset at step 10 -> start/write ignored, reset gives hi=lo=0, busy=0, no done pulse.
REQ-037 WIDTH=8, back-to-back DIVU 200/7 then start in done cycle with MULT -> lo=28, hi=4, then second done 9 cycles later with correct product.
